div_req_ctrl: RTL and testbench

- Upstream/downstream controller for the 8-bit sequential restoring divider.
- Buffers operand requests in a small FIFO and launches the divider with a one-cycle start pulse, presenting operands on the same cycle.
- Waits for the divider's done pulse, captures quotient and remainder, and returns them to the requester over a valid/ready response port.
- Handles divide-by-zero locally, without launching the divider, and flags a divider timeout.

---
 rtl/div_req_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_div_req_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_req_ctrl
// Brief    : Queues divide requests, sequences the 8-bit divider and returns
//            quotient/remainder (with divide-by-zero and timeout flags).
// Revision : 1.0 - initial release
// ============================================================================
module div_req_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_dividend,
    input  logic [7:0] req_divisor,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_quot,
    output logic [7:0] rsp_rem,
    output logic       rsp_dbz,
    output logic       rsp_err,
    output logic       div_start,
    output logic [7:0] div_inbus1,
    output logic [7:0] div_inbus2,
    input  logic [7:0] div_cat,
    input  logic [7:0] div_rest,
    input  logic       div_done,
    output logic       busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [AW:0]   C_FULL     = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   C_CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] C_TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] C_TMO_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop, load;
    logic [7:0]    head_dividend, head_divisor;

    state_t        state_q, state_d;
    logic [7:0]    a_q, a_d, b_q, b_d;
    logic [7:0]    quot_q, quot_d, rem_q, rem_d;
    logic          dbz_q, dbz_d, err_q, err_d;
    logic          valid_q, valid_d, start_q, start_d, busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign req_ready     = (count_q != C_FULL);
    assign push          = req_valid && req_ready;
    assign head_dividend = mem_q[rd_ptr_q][15:8];
    assign head_divisor  = mem_q[rd_ptr_q][7:0];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        err_d   = err_q;
        valid_d = valid_q;
        start_d = 1'b0;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE:   load = (count_q != '0);
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done is tested first so it wins over a coincident timeout
                if (div_done) begin
                    quot_d  = div_cat;
                    rem_d   = div_rest;
                    dbz_d   = 1'b0;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q == C_TMO_LAST) begin
                    quot_d  = 8'h00;
                    rem_d   = 8'h00;
                    dbz_d   = 1'b0;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + C_TMO_ONE;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                    load    = (count_q != '0);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pop bypasses IDLE: zero divisors answer locally, others launch
        if (load) begin
            a_d = head_dividend;
            b_d = head_divisor;
            if (head_divisor == 8'h00) begin
                quot_d  = 8'hFF;
                rem_d   = head_dividend;
                dbz_d   = 1'b1;
                err_d   = 1'b0;
                valid_d = 1'b1;
                state_d = S_RESP;
            end else begin
                start_d = 1'b1;
                state_d = S_LAUNCH;
            end
        end
        busy_d = (state_d != S_IDLE);
    end

    always_comb begin
        pop      = load;
        wr_ptr_d = push ? (wr_ptr_q + C_PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + C_PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + C_CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - C_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_dividend, req_divisor};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            quot_q   <= 8'h00;
            rem_q    <= 8'h00;
            dbz_q    <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            a_q      <= a_d;
            b_q      <= b_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rsp_valid  = valid_q;
    assign rsp_quot   = quot_q;
    assign rsp_rem    = rem_q;
    assign rsp_dbz    = dbz_q;
    assign rsp_err    = err_q;
    assign div_start  = start_q;
    assign div_inbus1 = a_q;
    assign div_inbus2 = b_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_div_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_req_ctrl
// Brief    : Directed self-checking bench for div_req_ctrl with a stub divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_req_ctrl;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 31;
    localparam int DIV_LAT = 8;

    localparam logic [7:0] B2B_A [5] = '{8'd9, 8'd20, 8'h7F, 8'd6, 8'd8};
    localparam logic [7:0] B2B_B [5] = '{8'd2, 8'd3,  8'd1,  8'd6, 8'd9};
    localparam logic [7:0] B2B_Q [5] = '{8'd4, 8'd6,  8'd127, 8'd1, 8'd0};
    localparam logic [7:0] B2B_R [5] = '{8'd1, 8'd2,  8'd0,  8'd0, 8'd8};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [7:0] req_dividend, req_divisor, rsp_quot, rsp_rem;
    logic       rsp_dbz, rsp_err, div_start, div_done, busy;
    logic [7:0] div_inbus1, div_inbus2;

    logic       stub_en   = 1'b1;
    logic       stub_done = 1'b0;
    logic       stub_busy = 1'b0;
    logic       tb_done;
    logic [7:0] stub_cat  = 8'h00;
    logic [7:0] stub_rest = 8'h00;
    logic [7:0] stub_a    = 8'h00;
    logic [7:0] stub_b    = 8'h01;
    logic [7:0] last_a    = 8'h00;
    logic [7:0] last_b    = 8'h00;
    int         stub_cnt  = 0;
    int         n_starts  = 0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_req_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quot(rsp_quot), .rsp_rem(rsp_rem),
        .rsp_dbz(rsp_dbz), .rsp_err(rsp_err),
        .div_start(div_start), .div_inbus1(div_inbus1), .div_inbus2(div_inbus2),
        .div_cat(stub_cat), .div_rest(stub_rest), .div_done(div_done),
        .busy(busy)
    );

    // Stub divider: done pulse DIV_LAT cycles after start; silent when stub_en=0
    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (div_start) begin
            n_starts  <= n_starts + 1;
            last_a    <= div_inbus1;
            last_b    <= div_inbus2;
            stub_a    <= div_inbus1;
            stub_b    <= div_inbus2;
            stub_busy <= stub_en;
            stub_cnt  <= DIV_LAT;
        end else if (stub_busy) begin
            if (stub_cnt == 1) begin
                stub_done <= 1'b1;
                stub_cat  <= stub_a / stub_b;
                stub_rest <= stub_a % stub_b;
                stub_busy <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    assign div_done = stub_done | tb_done;

    task automatic test_reset;
        #1 rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (div_start !== 1'b0) begin n_fail++; $display("FAIL reset_div_start: got %b expected 0", div_start); end
        n_checks++; if ({rsp_quot, rsp_rem, rsp_dbz, rsp_err} !== 18'd0) begin n_fail++; $display("FAIL reset_rsp_fields: got %h/%h/%b/%b expected all 0", rsp_quot, rsp_rem, rsp_dbz, rsp_err); end
        n_checks++; if ({div_inbus1, div_inbus2} !== 16'd0) begin n_fail++; $display("FAIL reset_inbus: got %h/%h expected 0/0", div_inbus1, div_inbus2); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int k;
        int s0;
        rsp_ready = 1'b1;
        s0 = n_starts;
        req_valid = 1'b1; req_dividend = 8'd100; req_divisor = 8'd7;
        @(negedge clk);
        req_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
        // accept cycle + pop + launch + 8-cycle stub + capture
        n_checks++; if (k !== 12) begin n_fail++; $display("FAIL single_latency: got %0d expected 12", k); end
        n_checks++; if (rsp_quot !== 8'd14 || rsp_rem !== 8'd2) begin n_fail++; $display("FAIL single_result: got q=%0d r=%0d expected q=14 r=2", rsp_quot, rsp_rem); end
        n_checks++; if (rsp_dbz !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_flags: got dbz=%b err=%b expected 0/0", rsp_dbz, rsp_err); end
        n_checks++; if (last_a !== 8'd100 || last_b !== 8'd7) begin n_fail++; $display("FAIL single_inbus: got %0d/%0d expected 100/7", last_a, last_b); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_width: got %b expected 0", rsp_valid); end
        n_checks++; if (n_starts - s0 !== 1) begin n_fail++; $display("FAIL single_starts: got %0d expected 1", n_starts - s0); end
    endtask

    task automatic test_dbz;
        int s0;
        rsp_ready = 1'b1;
        s0 = n_starts;
        req_valid = 1'b1; req_dividend = 8'd55; req_divisor = 8'd0;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL dbz_early_valid: got %b expected 0", rsp_valid); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL dbz_valid: got %b expected 1", rsp_valid); end
        n_checks++; if (rsp_quot !== 8'hFF || rsp_rem !== 8'd55) begin n_fail++; $display("FAIL dbz_result: got q=%h r=%0d expected q=ff r=55", rsp_quot, rsp_rem); end
        n_checks++; if (rsp_dbz !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL dbz_flags: got dbz=%b err=%b expected 1/0", rsp_dbz, rsp_err); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL dbz_after: got valid=%b busy=%b expected 0/0", rsp_valid, busy); end
        n_checks++; if (n_starts - s0 !== 0) begin n_fail++; $display("FAIL dbz_starts: got %0d expected 0", n_starts - s0); end
    endtask

    task automatic test_back_to_back;
        int k;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, req_ready); end
            req_valid = 1'b1; req_dividend = B2B_A[i]; req_divisor = B2B_B[i];
            @(negedge clk);
        end
        req_valid = 1'b0;
        // first request is already in the divider; the other DEPTH fill the FIFO
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got req_ready=%b expected 0", req_ready); end
        for (int i = 0; i < 5; i++) begin
            k = 0;
            while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
            n_checks++; if (rsp_valid !== 1'b1 || rsp_quot !== B2B_Q[i] || rsp_rem !== B2B_R[i]) begin n_fail++; $display("FAIL b2b_rsp_%0d: got v=%b q=%0d r=%0d expected v=1 q=%0d r=%0d", i, rsp_valid, rsp_quot, rsp_rem, B2B_Q[i], B2B_R[i]); end
            if (i == 0) begin
                n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_still_full: got %b expected 0", req_ready); end
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            if (i == 0) begin
                n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_reopen: got %b expected 1", req_ready); end
            end
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got busy=%b expected 0", busy); end
    endtask

    task automatic test_timeout;
        int k;
        rsp_ready = 1'b0;
        stub_en   = 1'b0;
        req_valid = 1'b1; req_dividend = 8'd50; req_divisor = 8'd5;
        @(negedge clk);
        req_dividend = 8'd77; req_divisor = 8'd7;
        @(negedge clk);
        req_valid = 1'b0;
        k = 2;
        while (!rsp_valid && k < 200) begin @(negedge clk); k++; end
        // pop + launch + TIMEOUT wait cycles, counted from the accept cycle
        n_checks++; if (k !== TIMEOUT + 3) begin n_fail++; $display("FAIL tmo_latency: got %0d expected %0d", k, TIMEOUT + 3); end
        n_checks++; if (rsp_err !== 1'b1 || rsp_dbz !== 1'b0) begin n_fail++; $display("FAIL tmo_flags: got err=%b dbz=%b expected 1/0", rsp_err, rsp_dbz); end
        n_checks++; if (rsp_quot !== 8'd0 || rsp_rem !== 8'd0) begin n_fail++; $display("FAIL tmo_result: got q=%0d r=%0d expected 0/0", rsp_quot, rsp_rem); end
        stub_en   = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (div_start !== 1'b1) begin n_fail++; $display("FAIL tmo_next_launch: got div_start=%b expected 1", div_start); end
        k = 0;
        while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_quot !== 8'd11 || rsp_rem !== 8'd0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL tmo_next_rsp: got v=%b q=%0d r=%0d err=%b expected v=1 q=11 r=0 err=0", rsp_valid, rsp_quot, rsp_rem, rsp_err); end
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_hold;
        int  k;
        int  s0;
        logic stable;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_dividend = 8'd200; req_divisor = 8'd10;
        @(negedge clk);
        req_dividend = 8'd45; req_divisor = 8'd4;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
        s0 = n_starts;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_quot !== 8'd20 || rsp_rem !== 8'd0 || div_start !== 1'b0) stable = 1'b0;
            @(negedge clk);
        end
        n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL hold_stable: got %b expected 1 (last v=%b q=%0d r=%0d)", stable, rsp_valid, rsp_quot, rsp_rem); end
        n_checks++; if (n_starts - s0 !== 0) begin n_fail++; $display("FAIL hold_no_start: got %0d expected 0", n_starts - s0); end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (div_start !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got start=%b valid=%b expected 1/0", div_start, rsp_valid); end
        k = 0;
        while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_quot !== 8'd11 || rsp_rem !== 8'd1) begin n_fail++; $display("FAIL hold_second: got v=%b q=%0d r=%0d expected v=1 q=11 r=1", rsp_valid, rsp_quot, rsp_rem); end
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int   s0;
        logic saw;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_dividend = 8'd90; req_divisor = 8'd9;
        @(negedge clk);
        req_dividend = 8'd30; req_divisor = 8'd3;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || div_start !== 1'b0) begin n_fail++; $display("FAIL mid_in_wait: got busy=%b start=%b expected 1/0", busy, div_start); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || div_start !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_async: got busy=%b valid=%b start=%b ready=%b expected 0/0/0/1", busy, rsp_valid, div_start, req_ready); end
        n_checks++; if ({div_inbus1, div_inbus2, rsp_quot, rsp_rem} !== 32'd0) begin n_fail++; $display("FAIL mid_async_data: got %h %h %h %h expected all 0", div_inbus1, div_inbus2, rsp_quot, rsp_rem); end
        @(negedge clk);
        rst = 1'b1;
        s0  = n_starts;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tb_done = (i == 15);
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) saw = 1'b1;
        end
        tb_done = 1'b0;
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL mid_late_done: got activity=%b expected 0", saw); end
        n_checks++; if (n_starts - s0 !== 0) begin n_fail++; $display("FAIL mid_flushed: got %0d starts expected 0", n_starts - s0); end
    endtask

    initial begin
        req_valid    = 1'b0;
        req_dividend = 8'h00;
        req_divisor  = 8'h00;
        rsp_ready    = 1'b0;
        tb_done      = 1'b0;
        test_reset();
        test_single();
        test_dbz();
        test_back_to_back();
        test_timeout();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
